// File: rtl/avi_info_frame_receiver_if.sv
// ============================================================================
// Module      : avi_info_frame_receiver_if
// Description : Byte-serial packet stream from the data-island decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avi_info_frame_receiver_if;
    logic       byte_valid;
    logic       byte_sop;
    logic [7:0] byte_data;

    modport master (output byte_valid, output byte_sop, output byte_data);
    modport slave  (input  byte_valid, input  byte_sop, input  byte_data);
endinterface

`default_nettype wire

// File: rtl/avi_info_frame_receiver.sv
// ============================================================================
// Module      : avi_info_frame_receiver
// Description : Validates HDMI AVI InfoFrame packets and latches decoded fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avi_info_frame_receiver #(
    parameter logic [7:0]  AVI_TYPE        = 8'h82,
    parameter logic [7:0]  MIN_VERSION     = 8'd2,
    parameter int unsigned ERR_COUNT_WIDTH = 8
) (
    input  wire logic                       clk_pixel,
    input  wire logic                       reset,
    avi_info_frame_receiver_if.slave        byte_if,
    output logic                            avi_valid,
    output logic                            avi_update,
    output logic                            checksum_error,
    output logic                            other_packet,
    output logic [ERR_COUNT_WIDTH-1:0]      err_count,
    output logic [1:0]                      video_format,
    output logic                            active_format_info_present,
    output logic [1:0]                      bar_info,
    output logic [1:0]                      scan_info,
    output logic [1:0]                      colorimetry,
    output logic [1:0]                      picture_aspect_ratio,
    output logic [3:0]                      active_format_aspect_ratio,
    output logic                            it_content,
    output logic [2:0]                      extended_colorimetry,
    output logic [1:0]                      rgb_quantization_range,
    output logic [1:0]                      non_uniform_picture_scaling,
    output logic [6:0]                      video_id_code,
    output logic [1:0]                      ycc_quantization_range,
    output logic [1:0]                      content_type,
    output logic [3:0]                      pixel_repetition
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_IDX     = 5'd30;
    localparam logic [4:0] C_LAST_SUM_IDX = 5'd16;
    localparam logic [4:0] C_HB2_LENGTH   = 5'd13;
    localparam logic [ERR_COUNT_WIDTH-1:0] C_ERR_MAX = {ERR_COUNT_WIDTH{1'b1}};

    state_t     r_state, w_state_nxt;
    logic [4:0] r_idx, w_idx_nxt;
    logic [7:0] r_sum, w_sum_nxt;

    // Shadow copies of PB1..PB5, promoted to the outputs only on a good checksum
    logic [6:0] r_sh_pb1, w_sh_pb1;
    logic [7:0] r_sh_pb2, w_sh_pb2;
    logic [7:0] r_sh_pb3, w_sh_pb3;
    logic [6:0] r_sh_pb4, w_sh_pb4;
    logic [7:0] r_sh_pb5, w_sh_pb5;

    logic [6:0] r_out_pb1;
    logic [7:0] r_out_pb2;
    logic [7:0] r_out_pb3;
    logic [6:0] r_out_pb4;
    logic [7:0] r_out_pb5;

    logic                       r_avi_valid;
    logic                       r_avi_update;
    logic                       r_checksum_error;
    logic                       r_other_packet;
    logic [ERR_COUNT_WIDTH-1:0] r_err_count;

    logic w_commit;
    logic w_cksum_bad;
    logic w_other;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sum_nxt   = r_sum;
        w_sh_pb1    = r_sh_pb1;
        w_sh_pb2    = r_sh_pb2;
        w_sh_pb3    = r_sh_pb3;
        w_sh_pb4    = r_sh_pb4;
        w_sh_pb5    = r_sh_pb5;
        w_commit    = 1'b0;
        w_cksum_bad = 1'b0;
        w_other     = 1'b0;

        if (byte_if.byte_valid) begin
            if (byte_if.byte_sop) begin
                // A sop always restarts, even mid-packet; the old packet is dropped silently
                w_idx_nxt   = 5'd1;
                w_sum_nxt   = byte_if.byte_data;
                w_state_nxt = (byte_if.byte_data == AVI_TYPE) ? ST_HDR : ST_SKIP;
            end else begin
                unique case (r_state)
                    ST_IDLE: ;
                    ST_HDR: begin
                        w_idx_nxt = r_idx + 5'd1;
                        w_sum_nxt = r_sum + byte_if.byte_data;
                        if (r_idx == 5'd1) begin
                            if (byte_if.byte_data < MIN_VERSION) begin
                                w_state_nxt = ST_SKIP;
                            end
                        end else begin
                            w_state_nxt = (byte_if.byte_data[4:0] == C_HB2_LENGTH) ? ST_BODY : ST_SKIP;
                        end
                    end
                    ST_BODY: begin
                        w_idx_nxt = r_idx + 5'd1;
                        if (r_idx <= C_LAST_SUM_IDX) begin
                            w_sum_nxt = r_sum + byte_if.byte_data;
                        end
                        case (r_idx)
                            5'd4:    w_sh_pb1 = byte_if.byte_data[6:0];
                            5'd5:    w_sh_pb2 = byte_if.byte_data;
                            5'd6:    w_sh_pb3 = byte_if.byte_data;
                            5'd7:    w_sh_pb4 = byte_if.byte_data[6:0];
                            5'd8:    w_sh_pb5 = byte_if.byte_data;
                            default: ;
                        endcase
                        if (r_idx == C_LAST_IDX) begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = 5'd0;
                            w_commit    = (r_sum == 8'd0);
                            w_cksum_bad = (r_sum != 8'd0);
                        end
                    end
                    ST_SKIP: begin
                        w_idx_nxt = r_idx + 5'd1;
                        if (r_idx == C_LAST_IDX) begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = 5'd0;
                            w_other     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_idx            <= 5'd0;
            r_sum            <= 8'd0;
            r_sh_pb1         <= 7'd0;
            r_sh_pb2         <= 8'd0;
            r_sh_pb3         <= 8'd0;
            r_sh_pb4         <= 7'd0;
            r_sh_pb5         <= 8'd0;
            r_out_pb1        <= 7'd0;
            r_out_pb2        <= 8'd0;
            r_out_pb3        <= 8'd0;
            r_out_pb4        <= 7'd0;
            r_out_pb5        <= 8'd0;
            r_avi_valid      <= 1'b0;
            r_avi_update     <= 1'b0;
            r_checksum_error <= 1'b0;
            r_other_packet   <= 1'b0;
            r_err_count      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_idx            <= w_idx_nxt;
            r_sum            <= w_sum_nxt;
            r_sh_pb1         <= w_sh_pb1;
            r_sh_pb2         <= w_sh_pb2;
            r_sh_pb3         <= w_sh_pb3;
            r_sh_pb4         <= w_sh_pb4;
            r_sh_pb5         <= w_sh_pb5;
            r_avi_update     <= w_commit;
            r_checksum_error <= w_cksum_bad;
            r_other_packet   <= w_other;
            if (w_commit) begin
                r_out_pb1   <= r_sh_pb1;
                r_out_pb2   <= r_sh_pb2;
                r_out_pb3   <= r_sh_pb3;
                r_out_pb4   <= r_sh_pb4;
                r_out_pb5   <= r_sh_pb5;
                r_avi_valid <= 1'b1;
            end
            if (w_cksum_bad && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_COUNT_WIDTH'(1);
            end
        end
    end

    assign avi_valid                   = r_avi_valid;
    assign avi_update                  = r_avi_update;
    assign checksum_error              = r_checksum_error;
    assign other_packet                = r_other_packet;
    assign err_count                   = r_err_count;

    assign video_format                = r_out_pb1[6:5];
    assign active_format_info_present  = r_out_pb1[4];
    assign bar_info                    = r_out_pb1[3:2];
    assign scan_info                   = r_out_pb1[1:0];
    assign colorimetry                 = r_out_pb2[7:6];
    assign picture_aspect_ratio        = r_out_pb2[5:4];
    assign active_format_aspect_ratio  = r_out_pb2[3:0];
    assign it_content                  = r_out_pb3[7];
    assign extended_colorimetry        = r_out_pb3[6:4];
    assign rgb_quantization_range      = r_out_pb3[3:2];
    assign non_uniform_picture_scaling = r_out_pb3[1:0];
    assign video_id_code               = r_out_pb4;
    assign ycc_quantization_range      = r_out_pb5[7:6];
    assign content_type                = r_out_pb5[5:4];
    assign pixel_repetition            = r_out_pb5[3:0];

endmodule

`default_nettype wire

// File: tb/tb_avi_info_frame_receiver.sv
// ============================================================================
// Module      : tb_avi_info_frame_receiver
// Description : Table-driven, scoreboarded bench for avi_info_frame_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avi_info_frame_receiver;

    localparam int K_UPD = 0;
    localparam int K_CKS = 1;
    localparam int K_OTH = 2;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       avi_valid, avi_update, checksum_error, other_packet;
    logic [7:0] err_count;
    logic [1:0] video_format, bar_info, scan_info, colorimetry, picture_aspect_ratio;
    logic       active_format_info_present, it_content;
    logic [3:0] active_format_aspect_ratio, pixel_repetition;
    logic [2:0] extended_colorimetry;
    logic [1:0] rgb_quantization_range, non_uniform_picture_scaling;
    logic [1:0] ycc_quantization_range, content_type;
    logic [6:0] video_id_code;

    always #5 clk_pixel = ~clk_pixel;

    avi_info_frame_receiver_if bus ();

    avi_info_frame_receiver dut (
        .clk_pixel                   (clk_pixel),
        .reset                       (reset),
        .byte_if                     (bus.slave),
        .avi_valid                   (avi_valid),
        .avi_update                  (avi_update),
        .checksum_error              (checksum_error),
        .other_packet                (other_packet),
        .err_count                   (err_count),
        .video_format                (video_format),
        .active_format_info_present  (active_format_info_present),
        .bar_info                    (bar_info),
        .scan_info                   (scan_info),
        .colorimetry                 (colorimetry),
        .picture_aspect_ratio        (picture_aspect_ratio),
        .active_format_aspect_ratio  (active_format_aspect_ratio),
        .it_content                  (it_content),
        .extended_colorimetry        (extended_colorimetry),
        .rgb_quantization_range      (rgb_quantization_range),
        .non_uniform_picture_scaling (non_uniform_picture_scaling),
        .video_id_code               (video_id_code),
        .ycc_quantization_range      (ycc_quantization_range),
        .content_type                (content_type),
        .pixel_repetition            (pixel_repetition)
    );

    typedef struct {
        logic [7:0] hb0, hb1, hb2, pb0, pb1, pb2, pb3, pb4, pb5, fill;
        bit         gaps;
        int         kind;
        int         vic, par, afar, rgbq, yccq, afi;
    } vec_t;

    typedef struct {
        int due;
        int upd, cks, oth, valid, err;
        int vic, par, afar, rgbq, yccq, afi;
    } exp_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    exp_t sb[$];
    exp_t nxt_exp;
    logic [7:0] pkt [0:30];
    vec_t vecs [0:8];

    int m_valid, m_err, m_vic, m_par, m_afar, m_rgbq, m_yccq, m_afi;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard: compare at the cycle a pulse is due, otherwise no pulse may appear
    always @(negedge clk_pixel) begin : monitor
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("avi_update",     int'(avi_update),     e.upd);
            check("checksum_error", int'(checksum_error), e.cks);
            check("other_packet",   int'(other_packet),   e.oth);
            check("avi_valid",      int'(avi_valid),      e.valid);
            check("err_count",      int'(err_count),      e.err);
            check("video_id_code",  int'(video_id_code),  e.vic);
            check("picture_aspect_ratio",       int'(picture_aspect_ratio),       e.par);
            check("active_format_aspect_ratio", int'(active_format_aspect_ratio), e.afar);
            check("rgb_quantization_range",     int'(rgb_quantization_range),     e.rgbq);
            check("ycc_quantization_range",     int'(ycc_quantization_range),     e.yccq);
            check("active_format_info_present", int'(active_format_info_present), e.afi);
        end else if (avi_update || checksum_error || other_packet) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stray_pulse: got upd=%0d cks=%0d oth=%0d, expected none (cycle %0d)",
                     avi_update, checksum_error, other_packet, cyc);
        end
    end

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_vic = 0; m_par = 0;
        m_afar = 0; m_rgbq = 0; m_yccq = 0; m_afi = 0;
    endtask

    task automatic prepare(input vec_t v);
        pkt[0] = v.hb0; pkt[1] = v.hb1; pkt[2] = v.hb2; pkt[3] = v.pb0;
        pkt[4] = v.pb1; pkt[5] = v.pb2; pkt[6] = v.pb3; pkt[7] = v.pb4; pkt[8] = v.pb5;
        for (int i = 9; i <= 16; i++) pkt[i] = 8'h00;
        for (int i = 17; i <= 30; i++) pkt[i] = v.fill;
    endtask

    task automatic expect_from(input vec_t v);
        if (v.kind == K_UPD) begin
            m_valid = 1; m_vic = v.vic; m_par = v.par; m_afar = v.afar;
            m_rgbq = v.rgbq; m_yccq = v.yccq; m_afi = v.afi;
        end else if (v.kind == K_CKS) begin
            if (m_err < 255) m_err++;
        end
        nxt_exp = '{0, int'(v.kind == K_UPD), int'(v.kind == K_CKS), int'(v.kind == K_OTH),
                    m_valid, m_err, m_vic, m_par, m_afar, m_rgbq, m_yccq, m_afi};
    endtask

    // Drive n bytes of pkt; a full packet queues its expectation on the PB27 slot
    task automatic send(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pixel); #1;
            bus.byte_valid = 1'b1;
            bus.byte_sop   = (i == 0);
            bus.byte_data  = pkt[i];
            if (i == 30) begin
                nxt_exp.due = cyc + 1;
                sb.push_back(nxt_exp);
            end
            if (gaps && i < n - 1) begin
                @(posedge clk_pixel); #1;
                bus.byte_valid = 1'b0;
                bus.byte_sop   = 1'b0;
                bus.byte_data  = 8'hFF;
            end
        end
    endtask

    task automatic run_full(input vec_t v);
        prepare(v);
        expect_from(v);
        send(31, v.gaps);
    endtask

    task automatic run_partial(input vec_t v, input int n);
        prepare(v);
        send(n, 1'b0);
    endtask

    task automatic go_idle();
        @(posedge clk_pixel); #1;
        bus.byte_valid = 1'b0;
        bus.byte_sop   = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk_pixel);
        check({tag, "_avi_valid"},  int'(avi_valid), 0);
        check({tag, "_pulses"},     int'({avi_update, checksum_error, other_packet}), 0);
        check({tag, "_err_count"},  int'(err_count), 0);
        check({tag, "_vic"},        int'(video_id_code), 0);
        check({tag, "_pb1_fields"}, int'({video_format, active_format_info_present, bar_info, scan_info}), 0);
        check({tag, "_pb2_fields"}, int'({colorimetry, picture_aspect_ratio, active_format_aspect_ratio}), 0);
        check({tag, "_pb3_fields"}, int'({it_content, extended_colorimetry, rgb_quantization_range,
                                          non_uniform_picture_scaling}), 0);
        check({tag, "_pb5_fields"}, int'({ycc_quantization_range, content_type, pixel_repetition}), 0);
    endtask

    initial begin
        //           hb0    hb1    hb2    pb0    pb1    pb2    pb3    pb4    pb5    fill  gaps kind  vic par afar rgbq yccq afi
        vecs[0] = '{8'h82, 8'h02, 8'h0D, 8'hEE, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_UPD, 16, 1, 9, 2, 1, 1};
        vecs[1] = '{8'h82, 8'h02, 8'h0D, 8'hEF, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_CKS, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{8'h84, 8'h02, 8'h0D, 8'hEE, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_OTH, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{8'h82, 8'h01, 8'h0D, 8'hEF, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_OTH, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{8'h82, 8'h02, 8'h0A, 8'hF1, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_OTH, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{8'h82, 8'h02, 8'h0D, 8'hFA, 8'h10, 8'h19, 8'h08, 8'h04, 8'h40, 8'h00, 1'b0, K_UPD, 4, 1, 9, 2, 1, 1};
        vecs[6] = '{8'h82, 8'h03, 8'h0D, 8'hED, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'h00, 1'b0, K_UPD, 16, 1, 9, 2, 1, 1};
        vecs[7] = '{8'h82, 8'h02, 8'h2D, 8'hDA, 8'h10, 8'h19, 8'h08, 8'h04, 8'h40, 8'h00, 1'b0, K_UPD, 4, 1, 9, 2, 1, 1};
        vecs[8] = '{8'h82, 8'h02, 8'h0D, 8'hEE, 8'h10, 8'h19, 8'h08, 8'h10, 8'h40, 8'hA5, 1'b1, K_UPD, 16, 1, 9, 2, 1, 1};

        bus.byte_valid = 1'b0;
        bus.byte_sop   = 1'b0;
        bus.byte_data  = 8'h00;
        reset          = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_pixel);
        #1 reset = 1'b0;
        check_all_zero("reset");

        // Back-to-back table frames: header rejects, checksum error, boundary versions, gaps
        for (int i = 0; i <= 8; i++) run_full(vecs[i]);
        go_idle();

        // sop at idx 10 aborts the VIC 16 frame and restarts as VIC 4
        run_partial(vecs[0], 10);
        run_full(vecs[5]);

        // sop on the PB27 slot is an abort, not an end of packet
        run_partial(vecs[5], 30);
        run_full(vecs[0]);
        go_idle();

        // Checksum error counter saturation
        for (int i = 0; i < 300; i++) run_full(vecs[1]);
        go_idle();
        repeat (2) @(negedge clk_pixel);
        check("err_count_saturated", int'(err_count), 255);
        check("valid_kept_after_errors", int'(avi_valid), 1);

        // Reset in the middle of a good frame
        run_partial(vecs[0], 20);
        @(posedge clk_pixel); #1;
        bus.byte_valid = 1'b0;
        bus.byte_sop   = 1'b0;
        reset          = 1'b1;
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        model_reset();
        check_all_zero("midreset");
        run_full(vecs[0]);
        go_idle();

        repeat (5) @(negedge clk_pixel);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
